program_load_sequencer: RTL and testbench

//  Boot controller in front of the processor core. Takes a host word stream (valid/ready) carrying
//  a header plus instruction and data images, and writes them one word per cycle via new_instruction/add_into.
//  It then raises start_signal and waits for end_signal, bounded by a watchdog. Replaces bench-driven loading.

---
 rtl/program_load_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_program_load_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_load_sequencer.sv
// Boot-time program loader: takes a host word stream (N_I, N_D, instruction image,
// data image), writes it into the core memories one word per cycle, then runs the
// core under a watchdog until it signals completion.
module program_load_sequencer #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int ADDR_W     = 6,
    parameter int WATCHDOG   = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic [31:0]       host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic [31:0]       new_instruction,
    output logic              add_into,
    output logic              load_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic              start_signal,
    input  logic              end_signal,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [31:0]       run_cycles
);

    typedef enum logic [3:0] {
        IDLE,
        HDR_I,
        HDR_D,
        LOAD_I,
        LOAD_D,
        SETTLE,
        RUN,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_SIZE  = 2'd1;
    localparam logic [1:0] ERR_WDOG  = 2'd2;
    localparam logic [1:0] ERR_EMPTY = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  err_d;
    logic [31:0] n_i_q, n_d_q;
    logic [31:0] cnt_q;
    logic        accept;
    logic        last_i, last_d;
    logic        timeout;
    logic        add_into_d;

    assign accept  = host_valid && host_ready;
    assign last_i  = (cnt_q == n_i_q - 32'd1);
    assign last_d  = (cnt_q == n_d_q - 32'd1);
    // The current RUN cycle is the WATCHDOG-th one.
    assign timeout = (run_cycles >= 32'(WATCHDOG - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; also selects the fault code when entering ERR.
    // NOTE: defaults are assigned first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        err_d   = 2'd0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE, ERR: if (go) state_d = HDR_I;
                HDR_I: if (accept) begin
                    if (host_data == 32'd0) begin
                        state_d = ERR;
                        err_d   = ERR_EMPTY;
                    end else if (host_data > 32'(IMEM_DEPTH)) begin
                        state_d = ERR;
                        err_d   = ERR_SIZE;
                    end else begin
                        state_d = HDR_D;
                    end
                end
                HDR_D: if (accept) begin
                    if (host_data > 32'(DMEM_DEPTH)) begin
                        state_d = ERR;
                        err_d   = ERR_SIZE;
                    end else begin
                        state_d = LOAD_I;
                    end
                end
                LOAD_I: if (accept && last_i) state_d = (n_d_q == 32'd0) ? SETTLE : LOAD_D;
                LOAD_D: if (accept && last_d) state_d = SETTLE;
                SETTLE: state_d = RUN;
                RUN: begin
                    // end_signal wins over a coincident watchdog expiry.
                    if (end_signal) begin
                        state_d = DONE;
                    end else if (timeout) begin
                        state_d = ERR;
                        err_d   = ERR_WDOG;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State-decoded outputs and the next value of the registered memory select.
    always_comb begin
        host_ready   = 1'b0;
        start_signal = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        unique case (state_q)
            HDR_I, HDR_D, LOAD_I, LOAD_D: begin
                host_ready = !abort;
                busy       = 1'b1;
            end
            SETTLE: busy = 1'b1;
            RUN: begin
                start_signal = 1'b1;
                busy         = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
        // add_into travels with its write, so the last instruction write keeps 0
        // even though the FSM has already moved past LOAD_I.
        if (state_q == LOAD_I && accept)
            add_into_d = 1'b0;
        else
            add_into_d = (state_d inside {LOAD_D, SETTLE, RUN, DONE, ERR});
    end

    // Header latches, image index, registered write port, fault code and run counter.
    // NOTE: every datapath register is reset, since outputs must read 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_i_q           <= '0;
            n_d_q           <= '0;
            cnt_q           <= '0;
            load_we         <= 1'b0;
            new_instruction <= '0;
            load_addr       <= '0;
            add_into        <= 1'b0;
            err_code        <= '0;
            run_cycles      <= '0;
        end else if (abort) begin
            n_i_q           <= '0;
            n_d_q           <= '0;
            cnt_q           <= '0;
            load_we         <= 1'b0;
            new_instruction <= '0;
            load_addr       <= '0;
            add_into        <= 1'b0;
            err_code        <= '0;
            run_cycles      <= '0;
        end else begin
            load_we  <= 1'b0;
            add_into <= add_into_d;
            unique case (state_q)
                IDLE, DONE, ERR: if (go) begin
                    err_code   <= '0;
                    run_cycles <= '0;
                    cnt_q      <= '0;
                end
                HDR_I: if (accept) n_i_q <= host_data;
                HDR_D: if (accept) begin
                    n_d_q <= host_data;
                    cnt_q <= '0;
                end
                LOAD_I, LOAD_D: if (accept) begin
                    load_we         <= 1'b1;
                    new_instruction <= host_data;
                    load_addr       <= cnt_q[ADDR_W-1:0];
                    // The data image indexes from 0 again.
                    cnt_q           <= (state_q == LOAD_I && last_i) ? 32'd0 : cnt_q + 32'd1;
                end
                RUN: if (run_cycles != 32'hFFFF_FFFF) run_cycles <= run_cycles + 32'd1;
                default: ;
            endcase
            if (state_d == ERR && state_q != ERR) err_code <= err_d;
        end
    end

endmodule

// File: tb/tb_program_load_sequencer.sv
// Directed bench for program_load_sequencer: expected memory writes are queued as
// image words are streamed and compared as the write port produces them.
module tb_program_load_sequencer;

    localparam int ADDR_W = 6;

    typedef struct {
        logic              add;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              go;
    logic              abort;
    logic [31:0]       host_data;
    logic              host_valid;
    logic              host_ready;
    logic [31:0]       new_instruction;
    logic              add_into;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic              start_signal;
    logic              end_signal;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [31:0]       run_cycles;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_writes = 0;

    program_load_sequencer #(
        .IMEM_DEPTH(64),
        .DMEM_DEPTH(64),
        .ADDR_W    (ADDR_W),
        .WATCHDOG  (1000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .abort          (abort),
        .host_data      (host_data),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .new_instruction(new_instruction),
        .add_into       (add_into),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .start_signal   (start_signal),
        .end_signal     (end_signal),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code),
        .run_cycles     (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every write the DUT issues must match the oldest queued word.
    always @(negedge clk) begin
        if (!reset && load_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", load_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_add_into", add_into, e.add);
                check("wr_addr", load_addr, e.addr);
                check("wr_data", new_instruction, e.data);
                n_writes++;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_host_ready"}, host_ready, 1'b0);
        check({tag, "_new_instr"}, new_instruction, 32'd0);
        check({tag, "_add_into"}, add_into, 1'b0);
        check({tag, "_load_we"}, load_we, 1'b0);
        check({tag, "_load_addr"}, load_addr, '0);
        check({tag, "_start"}, start_signal, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_err_code"}, err_code, 2'd0);
        check({tag, "_run_cycles"}, run_cycles, 32'd0);
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    // Offer one word; returns #1 after the edge that accepted it.
    task automatic send(input logic [31:0] w, input bit gap);
        logic rdy;
        int   n;
        if (gap) begin
            host_valid = 1'b0;
            @(posedge clk); #1;
        end
        host_data  = w;
        host_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = host_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("ready_timeout", rdy, 1'b1);
        host_valid = 1'b0;
    endtask

    task automatic load(input int ni, input int nd, input int n_send, input bit gap);
        logic [31:0] w;
        int          sent;
        send(32'(ni), gap);
        send(32'(nd), gap);
        sent = 0;
        for (int i = 0; i < ni && sent < n_send; i++) begin
            w = $urandom;
            exp_q.push_back('{1'b0, ADDR_W'(i), w});
            send(w, gap);
            sent++;
        end
        for (int i = 0; i < nd && sent < n_send; i++) begin
            w = $urandom;
            exp_q.push_back('{1'b1, ADDR_W'(i), w});
            send(w, gap);
            sent++;
        end
    endtask

    // Called right after the final image word is accepted: its write lands in
    // SETTLE, and the core is started the cycle after.
    task automatic check_settle(input string tag, input int n_words);
        @(negedge clk);
        check({tag, "_last_we"}, load_we, 1'b1);
        check({tag, "_settle_start"}, start_signal, 1'b0);
        check({tag, "_settle_busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_run_start"}, start_signal, 1'b1);
        check({tag, "_run_we"}, load_we, 1'b0);
        check({tag, "_run_ready"}, host_ready, 1'b0);
        check({tag, "_run_add_into"}, add_into, 1'b1);
        check({tag, "_q_empty"}, exp_q.size(), 0);
        check({tag, "_n_writes"}, n_writes, n_words);
    endtask

    // Entered at the negedge of RUN cycle 1; end_signal is high during RUN cycle k (k >= 2).
    // A go pulse in cycle 1 must be ignored.
    task automatic run_to_done(input string tag, input int k);
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (k - 2) @(posedge clk);
        #1 end_signal = 1'b1;
        @(posedge clk); #1 end_signal = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_start"}, start_signal, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_run_cycles"}, run_cycles, 32'(k));
        check({tag, "_add_into"}, add_into, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        go         = 1'b0;
        abort      = 1'b0;
        host_data  = '0;
        host_valid = 1'b0;
        end_signal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // T1/T2: full load at one word per cycle, then a 500-cycle run.
        pulse_go();
        n_writes = 0;
        load(23, 11, 34, 1'b0);
        check_settle("t1", 34);
        run_to_done("t2", 500);

        // T3: oversize and empty headers.
        pulse_go();
        send(32'd65, 1'b0);
        @(negedge clk);
        check("t3_big_error", error, 1'b1);
        check("t3_big_code", err_code, 2'd1);
        check("t3_big_busy", busy, 1'b0);
        check("t3_big_we", load_we, 1'b0);
        pulse_go();
        send(32'd0, 1'b0);
        @(negedge clk);
        check("t3_empty_error", error, 1'b1);
        check("t3_empty_code", err_code, 2'd3);
        pulse_go();
        send(32'd1, 1'b0);
        send(32'd65, 1'b0);
        @(negedge clk);
        check("t3_dbig_code", err_code, 2'd1);
        check("t3_dbig_ready", host_ready, 1'b0);

        // T4: instruction-only image with host_valid toggling.
        pulse_go();
        check("t4_cleared_error", error, 1'b0);
        n_writes = 0;
        load(5, 0, 5, 1'b1);
        check_settle("t4", 5);
        run_to_done("t4", 3);

        // T5: watchdog expiry, then end_signal coincident with expiry.
        pulse_go();
        n_writes = 0;
        load(2, 1, 3, 1'b0);
        check_settle("t5a", 3);
        repeat (999) @(posedge clk);
        @(negedge clk);
        check("t5a_still_run", start_signal, 1'b1);
        check("t5a_no_err_yet", error, 1'b0);
        @(negedge clk);
        check("t5a_error", error, 1'b1);
        check("t5a_code", err_code, 2'd2);
        check("t5a_start", start_signal, 1'b0);
        check("t5a_run_cycles", run_cycles, 32'd1000);
        pulse_go();
        n_writes = 0;
        load(2, 1, 3, 1'b0);
        check_settle("t5b", 3);
        run_to_done("t5b", 1000);
        check("t5b_code", err_code, 2'd0);

        // T6: reset in the middle of the load, clean re-stream, abort during RUN.
        pulse_go();
        load(23, 11, 10, 1'b0);
        #1 reset = 1'b1;
        #1 check_all_zero("t6_reset");
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        pulse_go();
        n_writes = 0;
        load(23, 11, 34, 1'b0);
        check_settle("t6", 34);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check_all_zero("t6_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
